// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Operands come in through a valid/ready handshake; the result is held until the consumer accepts it.
module serial_ripple_subtractor #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // state | meaning
    // IDLE  | waiting for an operand set, in_ready=1
    // RUN   | one result bit per cycle, LSB first
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_nx;

    logic [WIDTH-1:0] m_sr, s_sr, d_sr, d_shift, diff_hold;
    logic             br, bout_hold;
    logic [CW-1:0]    cnt;
    logic             m, s, d, nb;

    assign m  = m_sr[0];
    assign s  = s_sr[0];
    assign d  = m ^ s ^ br;
    assign nb = (~m & s) | (~m & br) | (s & br);

    generate
        if (WIDTH == 1) begin : g_w1
            assign d_shift = d;
        end else begin : g_wn
            assign d_shift = {d, d_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // d_sr and br are reused by the next operation, so a copy is taken at the
    // handshake to keep diff/bout stable until the next result appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sr      <= '0;
            s_sr      <= '0;
            d_sr      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff_hold <= '0;
            bout_hold <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_sr <= minuend;
                        s_sr <= subtrahend;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    d_sr <= d_shift;
                    m_sr <= m_sr >> 1;
                    s_sr <= s_sr >> 1;
                    br   <= nb;
                    cnt  <= cnt + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        diff_hold <= d_sr;
                        bout_hold <= br;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = out_valid ? d_sr : diff_hold;
    assign bout      = out_valid ? br : bout_hold;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor at WIDTH=2 and WIDTH=8.
module tb_serial_ripple_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv2 = 1'b0, or2 = 1'b0, b2 = 1'b0;
    logic [1:0] m2 = '0, s2 = '0;
    logic       ir2, ov2, bo2;
    logic [1:0] d2;

    logic       iv8 = 1'b0, or8 = 1'b0, b8 = 1'b0;
    logic [7:0] m8 = '0, s8 = '0;
    logic       ir8, ov8, bo8;
    logic [7:0] d8;

    serial_ripple_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .minuend(m2), .subtrahend(s2), .bin(b2),
        .out_valid(ov2), .out_ready(or2), .diff(d2), .bout(bo2));

    serial_ripple_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .minuend(m8), .subtrahend(s8), .bin(b8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8));

    typedef struct {
        logic       w8;
        logic [7:0] m;
        logic [7:0] s;
        logic       b;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    int tests = 0;
    int failed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] cur_d(input logic w8);
        return w8 ? d8 : {6'b0, d2};
    endfunction
    function automatic logic cur_bo(input logic w8);
        return w8 ? bo8 : bo2;
    endfunction
    function automatic logic cur_ov(input logic w8);
        return w8 ? ov8 : ov2;
    endfunction
    function automatic logic cur_ir(input logic w8);
        return w8 ? ir8 : ir2;
    endfunction

    task automatic op(input logic w8, input logic [7:0] m, input logic [7:0] s,
                      input logic b, input logic [7:0] ed, input logic eb, input string nm);
        int lat;
        @(negedge clk);
        if (w8) begin m8 = m; s8 = s; b8 = b; iv8 = 1'b1; end
        else    begin m2 = m[1:0]; s2 = s[1:0]; b2 = b; iv2 = 1'b1; end
        chk({nm, ".in_ready"}, 32'(cur_ir(w8)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv2 = 1'b0; iv8 = 1'b0;
        lat = 1;
        while (!cur_ov(w8) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".latency"}, 32'(lat), w8 ? 32'd9 : 32'd3);
        chk({nm, ".diff"}, 32'(cur_d(w8)), 32'(ed));
        chk({nm, ".bout"}, 32'(cur_bo(w8)), 32'(eb));
        if (w8) or8 = 1'b1; else or2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or2 = 1'b0; or8 = 1'b0;
        chk({nm, ".idle_ready"}, 32'(cur_ir(w8)), 32'd1);
        chk({nm, ".idle_valid"}, 32'(cur_ov(w8)), 32'd0);
        chk({nm, ".diff_held"}, 32'(cur_d(w8)), 32'(ed));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 8'h03, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 1'b1};
        vecs[3] = '{1'b0, 8'h02, 8'h03, 1'b1, 8'h02, 1'b1};
        vecs[4] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[5] = '{1'b1, 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};
        vecs[6] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{1'b1, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};

        #12;
        chk("reset.in_ready", 32'(ir2), 32'd1);
        chk("reset.out_valid", 32'(ov2), 32'd0);
        chk("reset.diff", 32'(d2), 32'd0);
        chk("reset.bout", 32'(bo2), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            op(vecs[i].w8, vecs[i].m, vecs[i].s, vecs[i].b, vecs[i].ed, vecs[i].eb,
               $sformatf("vec%0d", i));

        for (int a = 0; a < 4; a++)
            for (int bb = 0; bb < 4; bb++)
                for (int c = 0; c < 2; c++) begin
                    int sum;
                    sum = a + bb + c;
                    op(1'b0, 8'(sum % 4), 8'(a), c[0], 8'(bb), sum > 3,
                       $sformatf("rt_a%0d_b%0d_c%0d", a, bb, c));
                end

        // backpressure: hold DONE for 5 cycles with a new operand waiting
        @(negedge clk);
        m2 = 2'd1; s2 = 2'd2; b2 = 1'b0; iv2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m2 = 2'd0; s2 = 2'd0; b2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp.out_valid", 32'(ov2), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp.diff%0d", k), 32'(d2), 32'd3);
            chk($sformatf("bp.bout%0d", k), 32'(bo2), 32'd1);
            chk($sformatf("bp.in_ready%0d", k), 32'(ir2), 32'd0);
            chk($sformatf("bp.valid%0d", k), 32'(ov2), 32'd1);
            @(negedge clk);
        end
        or2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or2 = 1'b0;
        chk("bp.idle_ready", 32'(ir2), 32'd1);
        chk("bp.idle_valid", 32'(ov2), 32'd0);
        @(posedge clk);
        @(negedge clk);
        iv2 = 1'b0;
        chk("bp.accepted", 32'(ir2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("bp.new_valid", 32'(ov2), 32'd1);
        chk("bp.new_diff", 32'(d2), 32'd3);
        chk("bp.new_bout", 32'(bo2), 32'd1);
        or2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or2 = 1'b0;

        // reset during the first RUN cycle, after a prior nonzero result
        op(1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b1, "pre_rst");
        @(negedge clk);
        m2 = 2'd3; s2 = 2'd1; b2 = 1'b0; iv2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv2 = 1'b0;
        chk("rst.in_run", 32'(ir2), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 32'(ov2), 32'd0);
        chk("rst.diff", 32'(d2), 32'd0);
        chk("rst.bout", 32'(bo2), 32'd0);
        chk("rst.in_ready", 32'(ir2), 32'd1);
        repeat (2) @(negedge clk);
        chk("rst.no_result", 32'(ov2), 32'd0);
        rst_n = 1'b1;
        op(1'b0, 8'h03, 8'h01, 1'b0, 8'h02, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
